switch_select_sequencer: RTL and testbench
==========================================

# switch_select_sequencer

Converts the two raw board push-buttons into a clean, registered 2-bit LED select for the 1-to-4 LED demux stage downstream. Each button is synchronized and debounced; a press-and-release of switch 1 steps the selected LED forward, and switch 2 steps it backward. The block replaces the direct switch-to-select wiring at the top level. It delivers a select that changes exactly once per deliberate button action.

## Interface
- DEBOUNCE_LIMIT, default 250000: consecutive stable cycles required to accept a new switch level (10 ms at 25 MHz); legal range ≥ 2.
- i_Clk  in  1  system clock; all logic on rising edge.
- i_Rst_L  in  1  reset, asynchronous assert, active-low.
- i_Switch_1  in  1  raw button 1, asynchronous to i_Clk, high = pressed.
- i_Switch_2  in  1  raw button 2, asynchronous to i_Clk, high = pressed.
- o_Sel0  out  1  select bit 0 (LSB) to demux.
- o_Sel1  out  1  select bit 1 (MSB) to demux.
- o_Step  out  1  one-cycle pulse on the cycle the select changes.
- o_Switch_1_Clean  out  1  debounced level of switch 1.
- o_Switch_2_Clean  out  1  debounced level of switch 2.

## Operation
- Per switch: a 2-flop synchronizer feeds a debounce filter. The filter has a stable register and a counter of width $clog2(DEBOUNCE_LIMIT).
- Filter rule:
  - If synced != stable, the counter increments.
  - On the cycle the counter equals DEBOUNCE_LIMIT-1 with synced still != stable, stable <= synced and the counter clears.
  - If synced == stable on any cycle, the counter clears. A glitch shorter than DEBOUNCE_LIMIT cycles is never accepted.
- Release detect: a registered falling edge of the stable level (1→0) produces one release event per switch.
- Select FSM: four states, SEL_LED1=2'b00, SEL_LED2=2'b01, SEL_LED3=2'b10, SEL_LED4=2'b11. The state drives {o_Sel1,o_Sel0} directly.
  - Release on switch 1 only: next state +1 modulo 4 (SEL_LED4 → SEL_LED1).
  - Release on switch 2 only: next state −1 modulo 4 (SEL_LED1 → SEL_LED4).
  - Both releases in the same cycle: state unchanged, o_Step stays 0.
  - No release: state unchanged.
- Holding a button produces no repeat; only the release counts.
- Reset (i_Rst_L=0, any time including mid-debounce) clears immediately, without waiting for a clock edge:
  - synchronizers, stable levels, counters, edge registers, o_Step: 0.
  - state: SEL_LED1.
  - The first release after reset needs a full debounced press first.

## Timing
- Raw edge to synchronized: 2 cycles.
- Synchronized change to stable update: DEBOUNCE_LIMIT cycles of uninterrupted difference.
- Stable 1→0 to release event: 1 cycle (edge register).
- Release event to state/o_Step: registered on the same edge. o_Step is high for exactly 1 cycle, concurrent with the new select value.
- Total, raw release (held clean) to new select: DEBOUNCE_LIMIT+3 cycles, ±1 for synchronizer sampling.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset deassertion is assumed synchronized externally; outputs hold reset values until the first edge after deassertion.

## Structure
- Shared package/header holds the state encodings SEL_LED1..SEL_LED4 and the default DEBOUNCE_LIMIT constant; the demux stage and top level use the same encodings.
- One sub-module, debounce_filter (synchronizer + counter + stable register, parameter DEBOUNCE_LIMIT), instantiated once per switch.
- Edge detect and the select FSM live in switch_select_sequencer itself.
- Top level wires o_Sel0/o_Sel1 to the demux select inputs in place of the raw switches.

## Test plan
Run with DEBOUNCE_LIMIT=4.
- Reset check: hold i_Rst_L=0 → {o_Sel1,o_Sel0}=00, o_Step=0, both clean levels 0. Assert reset mid-count → all registers clear on the same cycle, no edge needed.
- Clean step forward: press switch 1 for 10 cycles, then release.
  - o_Switch_1_Clean rises 6 cycles after the press (2 sync + 4 debounce).
  - After release, the select goes 00→01 with a single o_Step pulse.
  - Repeat 3 more times → 10, 11, 00 (wrap).
- Step backward and wrap: from reset, one clean press/release of switch 2 → select 11. A second one → 10.
- Bounce rejection: toggle switch 1 every 2 cycles for 20 cycles, then hold low → clean level never rises, select unchanged, o_Step never asserted.
- Simultaneous releases: press both for 10 cycles, release both on the same cycle → both clean levels fall on the same cycle, select unchanged, o_Step=0.
- Hold without release: hold switch 1 high for 100 cycles → clean level 1 throughout, select unchanged until release, then exactly one step.

Source files
------------

// File: rtl/switch_select_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// switch_select_sequencer_pkg
// Shared definitions for the LED select path: the select-state encodings that
// the sequencer drives and the 1-to-4 LED demux decodes, the default debounce
// length, and the modulo-4 stepping helper used by the select FSM.
// -----------------------------------------------------------------------------
package switch_select_sequencer_pkg;

  // Select encodings; the value is the demux select {sel1, sel0}.
  typedef enum logic [1:0] {
    SEL_LED1 = 2'b00,
    SEL_LED2 = 2'b01,
    SEL_LED3 = 2'b10,
    SEL_LED4 = 2'b11
  } sel_state_t;

  // 10 ms of stable level at a 25 MHz system clock.
  localparam int DEBOUNCE_LIMIT_DEFAULT = 250000;

  // Next select for one cycle of release events. A forward-only release steps
  // +1, a backward-only release steps -1 (both wrap modulo 4 through the 2-bit
  // arithmetic), and simultaneous or absent releases hold the current select.
  function automatic sel_state_t sel_next(input sel_state_t cur,
                                          input logic       fwd,
                                          input logic       back);
    logic [1:0] v;
    v = cur;
    if (fwd && !back) begin
      v = v + 2'd1;
    end else if (back && !fwd) begin
      v = v - 2'd1;
    end
    return sel_state_t'(v);
  endfunction

endpackage

// File: rtl/switch_select_sequencer_if.sv
// -----------------------------------------------------------------------------
// switch_select_sequencer_if
// Board-side bundle of the switch select sequencer: the two raw push-buttons
// in, and the registered LED select, step pulse and debounced levels out.
//   i_Switch_1 / i_Switch_2         raw buttons, asynchronous, high = pressed
//   o_Sel0 / o_Sel1                 demux select bits (LSB / MSB)
//   o_Step                          one-cycle pulse when the select changes
//   o_Switch_1_Clean / _2_Clean     debounced button levels
// master : the board / stimulus side (drives buttons, observes outputs)
// slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface switch_select_sequencer_if;

  logic i_Switch_1;
  logic i_Switch_2;
  logic o_Sel0;
  logic o_Sel1;
  logic o_Step;
  logic o_Switch_1_Clean;
  logic o_Switch_2_Clean;

  modport master (
    output i_Switch_1,
    output i_Switch_2,
    input  o_Sel0,
    input  o_Sel1,
    input  o_Step,
    input  o_Switch_1_Clean,
    input  o_Switch_2_Clean
  );

  modport slave (
    input  i_Switch_1,
    input  i_Switch_2,
    output o_Sel0,
    output o_Sel1,
    output o_Step,
    output o_Switch_1_Clean,
    output o_Switch_2_Clean
  );

endinterface

// File: rtl/switch_select_sequencer_debounce_filter.sv
// -----------------------------------------------------------------------------
// debounce_filter
// Cleans one raw push-button: a 2-flop synchronizer followed by a counter
// filter. The stable level only follows the synchronized input after it has
// differed from the stable level for DEBOUNCE_LIMIT consecutive cycles; any
// cycle of agreement restarts the count, so shorter glitches never pass.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   raw    raw button level, asynchronous to clk
//   clean  debounced, registered level
// -----------------------------------------------------------------------------
module debounce_filter
  import switch_select_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      stable  <= 1'b0;
      cnt     <= '0;
    end else begin
      // synchronizer stage boundary: raw -> sync_p0 -> sync_p1
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // filter stage boundary: the cycle that sees CNT_LAST with the
      // difference still present is the DEBOUNCE_LIMIT-th such cycle
      if (sync_p1 != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= sync_p1;
          cnt    <= '0;
        end else begin
          cnt    <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign clean = stable;

endmodule

// File: rtl/switch_select_sequencer.sv
// -----------------------------------------------------------------------------
// switch_select_sequencer
// Turns the two board push-buttons into a registered 2-bit LED select for the
// 1-to-4 LED demux. Each button is synchronized and debounced; releasing
// button 1 steps the select forward, releasing button 2 steps it backward,
// both modulo 4. Releasing both in the same cycle is ignored.
// Ports:
//   i_Clk    system clock, rising edge
//   i_Rst_L  asynchronous active-low reset
//   bus      switch_select_sequencer_if.slave
//            (raw buttons in; select, step pulse, clean levels out)
// -----------------------------------------------------------------------------
module switch_select_sequencer
  import switch_select_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst_L,
  switch_select_sequencer_if.slave  bus
);

  logic       clean_1;
  logic       clean_2;
  logic       clean_1_d;
  logic       clean_2_d;
  logic       release_1;
  logic       release_2;
  sel_state_t state;
  logic       step;

  debounce_filter #(
    .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT)
  ) u_debounce_1 (
    .clk   (i_Clk),
    .rst_n (i_Rst_L),
    .raw   (bus.i_Switch_1),
    .clean (clean_1)
  );

  debounce_filter #(
    .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT)
  ) u_debounce_2 (
    .clk   (i_Clk),
    .rst_n (i_Rst_L),
    .raw   (bus.i_Switch_2),
    .clean (clean_2)
  );

  // edge stage boundary: previous clean levels for release detection
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      clean_1_d <= 1'b0;
      clean_2_d <= 1'b0;
    end else begin
      clean_1_d <= clean_1;
      clean_2_d <= clean_2;
    end
  end

  // A release is the stable level going 1 -> 0; holding produces nothing.
  assign release_1 = clean_1_d & ~clean_1;
  assign release_2 = clean_2_d & ~clean_2;

  // select stage boundary: state and step pulse update on the same edge
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state <= SEL_LED1;
      step  <= 1'b0;
    end else begin
      case (state)
        SEL_LED1, SEL_LED2, SEL_LED3, SEL_LED4: begin
          state <= sel_next(state, release_1, release_2);
        end
        default: begin
          state <= SEL_LED1;
        end
      endcase
      // simultaneous releases cancel, so only an odd count steps
      step <= release_1 ^ release_2;
    end
  end

  assign bus.o_Sel0           = state[0];
  assign bus.o_Sel1           = state[1];
  assign bus.o_Step           = step;
  assign bus.o_Switch_1_Clean = clean_1;
  assign bus.o_Switch_2_Clean = clean_2;

endmodule

// File: tb/tb_switch_select_sequencer.sv
// -----------------------------------------------------------------------------
// tb_switch_select_sequencer
// Self-checking bench for switch_select_sequencer with DEBOUNCE_LIMIT=4.
// The reference model keeps a history of raw button samples and derives the
// clean level, release events, select and step pulse from the behavioural
// rules (sync delay, N consecutive differing samples, 1->0 of clean level).
// -----------------------------------------------------------------------------
module tb_switch_select_sequencer;
  import switch_select_sequencer_pkg::*;

  localparam int LIM = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  switch_select_sequencer_if bus ();

  switch_select_sequencer #(
    .DEBOUNCE_LIMIT (LIM)
  ) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // reference model state
  logic [15:0] h1, h2;        // raw samples, [0] = newest edge
  logic        m_c1, m_c2;    // clean level after the latest edge
  logic        m_c1d, m_c2d;  // clean level one edge earlier
  int          m_sel;
  logic        m_step;

  function automatic void model_reset();
    h1 = '0; h2 = '0;
    m_c1 = 1'b0; m_c2 = 1'b0; m_c1d = 1'b0; m_c2d = 1'b0;
    m_sel = 0; m_step = 1'b0;
  endfunction

  // Clean level flips when the synchronized input (raw two edges late) has
  // differed from it on each of the last LIM edges.
  function automatic logic flips(input logic [15:0] h, input logic c);
    logic all_diff;
    all_diff = 1'b1;
    for (int j = 2; j <= LIM + 1; j++) begin
      if (h[j] == c) all_diff = 1'b0;
    end
    return all_diff;
  endfunction

  function automatic void model_edge(input logic s1, input logic s2);
    logic r1, r2;
    h1 = {h1[14:0], s1};
    h2 = {h2[14:0], s2};
    r1 = m_c1d & ~m_c1;
    r2 = m_c2d & ~m_c2;
    m_c1d = m_c1;
    m_c2d = m_c2;
    if (flips(h1, m_c1)) m_c1 = ~m_c1;
    if (flips(h2, m_c2)) m_c2 = ~m_c2;
    m_step = r1 ^ r2;
    if (r1 && !r2) m_sel = (m_sel + 1) % 4;
    if (r2 && !r1) m_sel = (m_sel + 3) % 4;
  endfunction

  function automatic logic [4:0] observed();
    return {bus.o_Sel1, bus.o_Sel0, bus.o_Step, bus.o_Switch_1_Clean, bus.o_Switch_2_Clean};
  endfunction

  function automatic logic [4:0] expected();
    logic [1:0] s;
    s = 2'(m_sel);
    return {s, m_step, m_c1, m_c2};
  endfunction

  function automatic logic [1:0] sel_now();
    return {bus.o_Sel1, bus.o_Sel0};
  endfunction

  // one clock edge; outputs are sampled 1 time unit after it
  task automatic tick();
    @(posedge clk);
    model_edge(bus.i_Switch_1, bus.i_Switch_2);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_Switch_1 = 1'b0;
    bus.i_Switch_2 = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_Switch_1 = 1'b1;
    bus.i_Switch_2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (observed() !== 5'b0) begin
        fails++;
        $display("FAIL reset_hold: got %b want %b", observed(), 5'b0);
      end
    end
    do_reset();
  endtask

  task automatic test_step_forward();
    int rise_at;
    int steps;
    logic [1:0] want;
    for (int r = 0; r < 4; r++) begin
      rise_at = -1;
      steps   = 0;
      bus.i_Switch_1 = 1'b1;
      for (int i = 1; i <= 22; i++) begin
        if (i == 11) bus.i_Switch_1 = 1'b0;
        tick();
        checks++;
        if (observed() !== expected()) begin
          fails++;
          $display("FAIL fwd_cycle: got %b want %b", observed(), expected());
        end
        if (rise_at < 0 && bus.o_Switch_1_Clean === 1'b1) rise_at = i;
        if (bus.o_Step === 1'b1) steps++;
      end
      want = 2'(r + 1);
      checks++;
      if (rise_at !== 6) begin
        fails++;
        $display("FAIL fwd_clean_latency: got %0d want %0d", rise_at, 6);
      end
      checks++;
      if (steps !== 1) begin
        fails++;
        $display("FAIL fwd_step_count: got %0d want %0d", steps, 1);
      end
      checks++;
      if (sel_now() !== want) begin
        fails++;
        $display("FAIL fwd_select: got %b want %b", sel_now(), want);
      end
    end
  endtask

  task automatic test_step_backward();
    logic [1:0] want [2];
    want[0] = 2'b11;
    want[1] = 2'b10;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      bus.i_Switch_2 = 1'b1;
      for (int i = 1; i <= 22; i++) begin
        if (i == 11) bus.i_Switch_2 = 1'b0;
        tick();
        checks++;
        if (observed() !== expected()) begin
          fails++;
          $display("FAIL back_cycle: got %b want %b", observed(), expected());
        end
      end
      checks++;
      if (sel_now() !== want[r]) begin
        fails++;
        $display("FAIL back_select: got %b want %b", sel_now(), want[r]);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    bus.i_Switch_1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (observed() !== expected()) begin
        fails++;
        $display("FAIL midrst_pre: got %b want %b", observed(), expected());
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (observed() !== 5'b0) begin
      fails++;
      $display("FAIL midrst_async_clear: got %b want %b", observed(), 5'b0);
    end
    do_reset();
    // a full press/release after reset steps from LED1 to LED2
    bus.i_Switch_1 = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      if (i == 11) bus.i_Switch_1 = 1'b0;
      tick();
      checks++;
      if (observed() !== expected()) begin
        fails++;
        $display("FAIL midrst_post: got %b want %b", observed(), expected());
      end
    end
    checks++;
    if (sel_now() !== 2'b01) begin
      fails++;
      $display("FAIL midrst_select: got %b want %b", sel_now(), 2'b01);
    end
  endtask

  task automatic test_bounce();
    logic [1:0] sel0;
    logic       rose;
    logic       stepped;
    sel0    = sel_now();
    rose    = 1'b0;
    stepped = 1'b0;
    for (int i = 0; i < 30; i++) begin
      bus.i_Switch_1 = (i < 20) ? ~i[1] : 1'b0;
      tick();
      checks++;
      if (observed() !== expected()) begin
        fails++;
        $display("FAIL bounce_cycle: got %b want %b", observed(), expected());
      end
      if (bus.o_Switch_1_Clean === 1'b1) rose = 1'b1;
      if (bus.o_Step === 1'b1) stepped = 1'b1;
    end
    checks++;
    if (rose !== 1'b0 || stepped !== 1'b0 || sel_now() !== sel0) begin
      fails++;
      $display("FAIL bounce_reject: got rose=%b step=%b sel=%b want rose=0 step=0 sel=%b",
               rose, stepped, sel_now(), sel0);
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] sel0;
    int fall1, fall2;
    logic stepped;
    sel0 = sel_now();
    fall1 = -1; fall2 = -1;
    stepped = 1'b0;
    bus.i_Switch_1 = 1'b1;
    bus.i_Switch_2 = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      if (i == 11) begin
        bus.i_Switch_1 = 1'b0;
        bus.i_Switch_2 = 1'b0;
      end
      tick();
      checks++;
      if (observed() !== expected()) begin
        fails++;
        $display("FAIL simul_cycle: got %b want %b", observed(), expected());
      end
      if (i > 11 && fall1 < 0 && bus.o_Switch_1_Clean === 1'b0) fall1 = i;
      if (i > 11 && fall2 < 0 && bus.o_Switch_2_Clean === 1'b0) fall2 = i;
      if (bus.o_Step === 1'b1) stepped = 1'b1;
    end
    checks++;
    if (fall1 !== 16 || fall2 !== 16) begin
      fails++;
      $display("FAIL simul_fall: got %0d/%0d want 16/16", fall1, fall2);
    end
    checks++;
    if (stepped !== 1'b0 || sel_now() !== sel0) begin
      fails++;
      $display("FAIL simul_hold: got step=%b sel=%b want step=0 sel=%b", stepped, sel_now(), sel0);
    end
  endtask

  task automatic test_hold();
    logic [1:0] sel0;
    logic [1:0] want;
    int   steps_hold, steps_rel;
    logic dropped;
    sel0 = sel_now();
    want = sel0 + 2'd1;
    steps_hold = 0; steps_rel = 0;
    dropped = 1'b0;
    bus.i_Switch_1 = 1'b1;
    for (int i = 1; i <= 112; i++) begin
      if (i == 101) bus.i_Switch_1 = 1'b0;
      tick();
      checks++;
      if (observed() !== expected()) begin
        fails++;
        $display("FAIL hold_cycle: got %b want %b", observed(), expected());
      end
      if (i >= 6 && i <= 102 && bus.o_Switch_1_Clean !== 1'b1) dropped = 1'b1;
      if (i <= 100 && (bus.o_Step === 1'b1 || sel_now() !== sel0)) steps_hold++;
      if (i > 100 && bus.o_Step === 1'b1) steps_rel++;
    end
    checks++;
    if (dropped !== 1'b0 || steps_hold !== 0) begin
      fails++;
      $display("FAIL hold_no_repeat: got dropped=%b changes=%0d want 0/0", dropped, steps_hold);
    end
    checks++;
    if (steps_rel !== 1 || sel_now() !== want) begin
      fails++;
      $display("FAIL hold_release: got steps=%0d sel=%b want 1 sel=%b", steps_rel, sel_now(), want);
    end
  endtask

  task automatic test_random();
    int t, len;
    t = 0;
    while (t < 1500) begin
      bus.i_Switch_1 = 1'($urandom_range(0, 1));
      bus.i_Switch_2 = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 12));
      for (int i = 0; i < len; i++) begin
        tick();
        checks++;
        if (observed() !== expected()) begin
          fails++;
          $display("FAIL random_cycle t=%0d: got %b want %b", t + i, observed(), expected());
        end
      end
      t += len;
    end
    bus.i_Switch_1 = 1'b0;
    bus.i_Switch_2 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (observed() !== expected()) begin
        fails++;
        $display("FAIL random_drain: got %b want %b", observed(), expected());
      end
    end
  endtask

  initial begin
    bus.i_Switch_1 = 1'b0;
    bus.i_Switch_2 = 1'b0;
    model_reset();
    test_reset();
    test_step_forward();
    test_step_backward();
    test_reset_mid_count();
    test_bounce();
    test_simultaneous();
    test_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
